// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// op encodings, FSM states and the iteration-counter width helper.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // ceil(log2(width)); constant-foldable so it can size the counter
    function automatic int cnt_width(input int width);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < width) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/busy/done handshake plus HI/LO read-out between the execute stage
// and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_iter.sv
// One iteration of the shared datapath: shift-add multiply step (right shift)
// or restoring divide step (left shift). Purely combinational.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    // The trial difference only matters when it is non-negative, where it
    // is below the divisor and therefore fits in WIDTH bits.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh[WIDTH-1:0] - opnd;
        q_bit   = 1'b0;
        acc_nxt = '0;
        if (div_mode) begin
            q_bit   = (rem_sh >= {1'b0, opnd});
            acc_nxt = {(q_bit ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Iterates on operand magnitudes and applies sign correction in a final cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; MTHI/MTLO complete here in one cycle
// ST_RUN  | WIDTH multiply/divide iterations, counter 0 .. WIDTH-1
// ST_FIX  | sign correction of the magnitude result, HI/LO write, done
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_e               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;

    logic                 op_mul;
    logic                 op_div;
    logic                 op_signed;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   iter_acc;
    logic                 iter_q;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_comb begin
        op_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        mag_a     = (op_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
        mag_b     = (op_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .acc      (acc),
        .opnd     (opnd),
        .div_mode (is_div),
        .acc_nxt  (iter_acc),
        .q_bit    (iter_q)
    );

    // Divide keeps the quotient bit in the slot vacated by the left shift.
    always_comb begin
        acc_step = is_div ? {iter_acc[2*WIDTH-1:1], iter_q} : iter_acc;
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        if (bus.op == OP_MTHI) begin
                            bus.hi   <= bus.src_a;
                            bus.done <= 1'b1;
                        end else if (bus.op == OP_MTLO) begin
                            bus.lo   <= bus.src_a;
                            bus.done <= 1'b1;
                        end else if (op_mul || op_div) begin
                            state    <= ST_RUN;
                            bus.busy <= 1'b1;
                            cnt      <= '0;
                            is_div   <= op_div;
                            opnd     <= op_div ? mag_b : mag_a;
                            acc      <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                            // divide by zero leaves the all-ones quotient uncorrected
                            neg_res  <= op_signed && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1])
                                        && !(op_div && (bus.src_b == '0));
                            neg_rem  <= op_signed && op_div && bus.src_a[WIDTH-1];
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.cancel) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        acc <= acc_step;
                        if (cnt == CNT_LAST) begin
                            state <= ST_FIX;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_FIX: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                    cnt      <= '0;
                    if (!bus.cancel) begin
                        bus.done <= 1'b1;
                        if (is_div) begin
                            bus.lo <= quo_fix;
                            bus.hi <= rem_fix;
                        end else begin
                            bus.lo <= prod_fix[WIDTH-1:0];
                            bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized ops
// against an arithmetic reference model of HI/LO.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    // Reference: architectural effect of one completed op on HI/LO.
    task automatic model_apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, sp, sq, sr;
        logic [63:0] up;
        case (op)
            3'd0: begin
                sa = $signed(a); sb = $signed(b); sp = sa * sb;
                exp_hi = sp[63:32]; exp_lo = sp[31:0];
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                exp_hi = up[63:32]; exp_lo = up[31:0];
            end
            3'd2, 3'd3: begin
                if (b == '0) begin
                    exp_hi = a; exp_lo = '1;
                end else if (op == 3'd2) begin
                    sa = $signed(a); sb = $signed(b);
                    sq = sa / sb; sr = sa % sb;
                    exp_lo = sq[31:0]; exp_hi = sr[31:0];
                end else begin
                    exp_lo = a / b; exp_hi = a % b;
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Starts an op at the current negedge; returns at the negedge of the done
    // cycle (or after a bounded wait with lat = 0).
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cyc);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.src_a = $urandom; bus.src_b = $urandom;
        lat = 0; busy_cyc = 0;
        for (int k = 1; k <= LAT + 8; k++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b, expected all zero",
                     bus.hi, bus.lo, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
    endtask

    task automatic test_multiply();
        int lat, bc;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        model_apply(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL multu_latency: got %0d, expected %0d", lat, LAT); end
        checks++;
        if (bc !== W + 1) begin errors++; $display("FAIL multu_busy_cycles: got %0d, expected %0d", bc, W + 1); end
        checks++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            errors++; $display("FAIL multu_max: got %h_%h, expected fffffffe_00000001", bus.hi, bus.lo);
        end
        issue(OP_MULT, -32'sd3, 32'sd7, lat, bc);
        model_apply(OP_MULT, -32'sd3, 32'sd7);
        checks++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo || lat !== LAT) begin
            errors++; $display("FAIL mult_mixed: got %h_%h lat %0d, expected %h_%h lat %0d",
                               bus.hi, bus.lo, lat, exp_hi, exp_lo, LAT);
        end
    endtask

    task automatic test_divide();
        int lat, bc;
        issue(OP_DIV, -32'sd7, 32'sd2, lat, bc);
        model_apply(OP_DIV, -32'sd7, 32'sd2);
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF || lat !== LAT) begin
            errors++; $display("FAIL div_neg: got lo=%h hi=%h lat %0d, expected lo=fffffffd hi=ffffffff lat %0d",
                               bus.lo, bus.hi, lat, LAT);
        end
        issue(OP_DIVU, 32'd7, 32'd2, lat, bc);
        model_apply(OP_DIVU, 32'd7, 32'd2);
        checks++;
        if (bus.lo !== 32'd3 || bus.hi !== 32'd1) begin
            errors++; $display("FAIL divu_basic: got lo=%h hi=%h, expected lo=3 hi=1", bus.lo, bus.hi);
        end
    endtask

    task automatic test_boundaries();
        int lat, bc;
        issue(OP_DIVU, 32'h1234, 32'h0, lat, bc);
        model_apply(OP_DIVU, 32'h1234, 32'h0);
        checks++;
        if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h1234 || lat !== LAT) begin
            errors++; $display("FAIL divu_by_zero: got lo=%h hi=%h lat %0d, expected lo=ffffffff hi=1234 lat %0d",
                               bus.lo, bus.hi, lat, LAT);
        end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        model_apply(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
            errors++; $display("FAIL div_overflow: got lo=%h hi=%h, expected lo=80000000 hi=0", bus.lo, bus.hi);
        end
        issue(OP_DIV, -32'sd5, 32'h0, lat, bc);
        model_apply(OP_DIV, -32'sd5, 32'h0);
        checks++;
        if (bus.lo !== exp_lo || bus.hi !== exp_hi) begin
            errors++; $display("FAIL div_signed_by_zero: got lo=%h hi=%h, expected lo=%h hi=%h",
                               bus.lo, bus.hi, exp_lo, exp_hi);
        end
    endtask

    task automatic test_cancel();
        bit seen_done;
        // cancel in RUN, with an ignored start while busy
        bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = $urandom; bus.src_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.src_a = ~exp_hi;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL cancel_busy_before: got %b, expected 1", bus.busy); end
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy_after: got %b, expected 0", bus.busy); end
        seen_done = 1'b0;
        repeat (LAT + 4) begin
            seen_done |= bus.done;
            @(negedge clk);
        end
        checks++;
        if (seen_done || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++; $display("FAIL cancel_run: got done=%b hi=%h lo=%h, expected done=0 hi=%h lo=%h",
                               seen_done, bus.hi, bus.lo, exp_hi, exp_lo);
        end
        // cancel during FIX suppresses the write
        bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'h1234_5678; bus.src_b = 32'h9ABC_DEF1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (W) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        seen_done = 1'b0;
        repeat (6) begin
            seen_done |= bus.done;
            @(negedge clk);
        end
        checks++;
        if (seen_done || bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++; $display("FAIL cancel_fix: got done=%b busy=%b hi=%h lo=%h, expected 0 0 %h %h",
                               seen_done, bus.busy, bus.hi, bus.lo, exp_hi, exp_lo);
        end
        // cancel alongside start in IDLE
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MTLO; bus.src_a = ~exp_lo;
        @(negedge clk);
        bus.op = OP_MULT;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.lo !== exp_lo) begin
            errors++; $display("FAIL cancel_idle_start: got done=%b busy=%b lo=%h, expected 0 0 %h",
                               bus.done, bus.busy, bus.lo, exp_lo);
        end
    endtask

    task automatic test_unknown_op();
        bit seen;
        seen = 1'b0;
        bus.start = 1'b1; bus.op = 3'd6; bus.src_a = ~exp_hi; bus.src_b = 32'd1;
        @(negedge clk);
        seen |= bus.done | bus.busy;
        bus.op = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin
            seen |= bus.done | bus.busy;
            @(negedge clk);
        end
        checks++;
        if (seen || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++; $display("FAIL unknown_op: got activity=%b hi=%h lo=%h, expected 0 %h %h",
                               seen, bus.hi, bus.lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        bus.start = 1'b1; bus.op = OP_MTHI; bus.src_a = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.op = OP_MTLO; bus.src_a = 32'h5A5A_5A5A;
        checks++;
        if (bus.done !== 1'b1 || bus.hi !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL mthi: got done=%b hi=%h, expected 1 a5a5a5a5", bus.done, bus.hi);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.lo !== 32'h5A5A_5A5A || bus.hi !== 32'hA5A5_A5A5 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mtlo: got done=%b hi=%h lo=%h busy=%b, expected 1 a5a5a5a5 5a5a5a5a 0",
                               bus.done, bus.hi, bus.lo, bus.busy);
        end
        exp_hi = 32'hA5A5_A5A5; exp_lo = 32'h5A5A_5A5A;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL move_done_pulse: got %b, expected 0", bus.done); end
        // next op issued in the done cycle of the previous one
        issue(OP_DIVU, 32'd1000, 32'd7, lat, bc);
        model_apply(OP_DIVU, 32'd1000, 32'd7);
        issue(OP_MULT, 32'hFFFF_FFF0, 32'd16, lat, bc);
        model_apply(OP_MULT, 32'hFFFF_FFF0, 32'd16);
        checks++;
        if (lat !== LAT || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++; $display("FAIL back_to_back: got %h_%h lat %0d, expected %h_%h lat %0d",
                               bus.hi, bus.lo, lat, exp_hi, exp_lo, LAT);
        end
    endtask

    task automatic test_random();
        int lat, bc, exp_lat;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = pick_operand();
            b  = pick_operand();
            issue(op, a, b, lat, bc);
            model_apply(op, a, b);
            exp_lat = (op >= 3'd4) ? 1 : LAT;
            checks++;
            if (lat !== exp_lat || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
                errors++; $display("FAIL random_%0d op%0d a=%h b=%h: got %h_%h lat %0d, expected %h_%h lat %0d",
                                   i, op, a, b, bus.hi, bus.lo, lat, exp_hi, exp_lo, exp_lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        int lat, bc;
        issue(OP_MTHI, 32'h1, 32'h0, lat, bc);
        issue(OP_MTLO, 32'h2, 32'h0, lat, bc);
        bus.start = 1'b1; bus.op = OP_MULT; bus.src_a = 32'h0000_1234; bus.src_b = 32'hFFFF_0001;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_op: got hi=%h lo=%h busy=%b done=%b, expected all zero",
                               bus.hi, bus.lo, bus.busy, bus.done);
        end
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (LAT + 4) begin
            seen_done |= bus.done | bus.busy;
            @(negedge clk);
        end
        checks++;
        if (seen_done || bus.hi !== '0 || bus.lo !== '0) begin
            errors++; $display("FAIL reset_mid_after: got activity=%b hi=%h lo=%h, expected 0 0 0",
                               seen_done, bus.hi, bus.lo);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_boundaries();
        test_cancel();
        test_unknown_op();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It replaces the single-cycle combinational MULT/MULTU/DIV/DIVU/MTHI/MTLO paths in the execute-stage ALU. It sits beside the ALU, owns HI/LO, and exposes them for MFHI/MFLO. Operations use a start/busy/done handshake, so the pipeline stalls on `busy` and can abort an in-flight operation on a flush.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4 and even.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request; sampled only when idle.
- `op` input 3: operation code from `muldiv_pkg`: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `src_a` input WIDTH: multiplicand, dividend, or MTHI/MTLO data.
- `src_b` input WIDTH: multiplier or divisor.
- `cancel` input 1: synchronous abort (pipeline flush).
- `busy` output 1: an iterative operation is in flight.
- `done` output 1: one-cycle pulse; HI/LO hold the new result in the same cycle.
- `hi` output WIDTH: registered HI.
- `lo` output WIDTH: registered LO.

## Operation
- **Reset.** State IDLE. `hi = 0`, `lo = 0`, `busy = 0`, `done = 0`, iteration counter 0.
- **States.**
  - IDLE: accepts `start`.
  - RUN: WIDTH iterations.
  - FIX: sign correction and HI/LO write.
  - Returns to IDLE.
- **Acceptance.** `start` is accepted only in IDLE with `cancel = 0`. Any `start` while busy is ignored, with no queueing. An unknown `op` on `start` is ignored: no state change, no `done`.
- **MTHI / MTLO.** Single-cycle. The target register is written at the accepting edge and the other register is unchanged. `done` is asserted the next cycle. `busy` is never asserted.
- **MULT / MULTU (shift-add).**
  - At acceptance, operand magnitudes are latched. For MULT, negative operands are two's-complement negated. The result sign is latched: a XOR b for signed, 0 for unsigned.
  - Each RUN cycle adds the shifted multiplicand when the current multiplier LSB is 1, then shifts. The accumulator is 2·WIDTH wide.
  - FIX negates the 2·WIDTH product if the sign is set. HI gets the upper half, LO the lower half.
- **DIV / DIVU (restoring, one quotient bit per cycle).**
  - Magnitudes are latched as for multiply.
  - FIX sets the quotient to negative if the operand signs differ (signed only). The remainder takes the dividend's sign. LO gets the quotient, HI the remainder.
- **Divide by zero** (`src_b = 0`, signed or unsigned): LO = all ones, HI = `src_a` unmodified. Full latency is still taken.
- **Signed overflow** (most-negative / −1): LO = most-negative, HI = 0. This falls out of the magnitude arithmetic and needs no special case.
- **Cancel.**
  - In RUN or FIX: state goes to IDLE at the next edge. HI/LO unchanged, no `done`, `busy` low the following cycle.
  - `cancel` with `start` in IDLE: the `start` is ignored.
  - `cancel` beats the FIX-cycle write.
- **Reset mid-operation.** Async clear to reset values. No `done`.

## Timing
- `start` is sampled at edge t (cycle t).
- **MUL/DIV.**
  - `busy` is high in cycles t+1 … t+WIDTH+1: RUN is t+1 … t+WIDTH, FIX is t+WIDTH+1.
  - HI/LO are updated at the end of t+WIDTH+1.
  - `done` is high in cycle t+WIDTH+2. `busy` is low in that same cycle.
  - Total latency is WIDTH+2; a new `start` can be accepted in cycle t+WIDTH+2.
- **MTHI/MTLO.** HI/LO are updated at edge t and `done` is high in cycle t+1. Back-to-back `start` every cycle is legal.
- **Outputs.** `hi`, `lo`, `busy`, `done` are all driven straight from flops, with no combinational path from inputs.
- **Counter.** Counts 0 … WIDTH−1 in RUN. RUN→FIX when the counter equals WIDTH−1; no wrap beyond that.

## Structure
- **`muldiv_pkg`** holds:
  - op encodings: MULT = 0, MULTU = 1, DIV = 2, DIVU = 3, MTHI = 4, MTLO = 5;
  - the state enum IDLE / RUN / FIX;
  - a counter-width function, clog2(WIDTH).
- **`muldiv_iter`** sub-module: combinational single-iteration datapath. Inputs are accumulator, operand and mode; outputs are the next accumulator plus the quotient bit. It holds no state.
- **Top level** holds the FSM, counter, operand/sign latches, FIX negation and the HI/LO registers.

## Test plan
All scenarios use WIDTH = 32.
- **MULTU, max operands.** 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. `done` exactly 34 cycles after the start edge; `busy` high for 33 cycles.
- **MULT, mixed signs.** −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- **DIV, negative dividend.** −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **DIVU.** 7 / 2 → LO = 3, HI = 1.
- **Boundaries.**
  - DIVU 0x1234 / 0 → LO = 0xFFFFFFFF, HI = 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Cancel and busy-start.**
  - `start` DIVU, `cancel` at cycle t+10 → `busy` = 0 at t+11, no `done`, HI/LO keep their previous values.
  - A `start` issued at t+5 is ignored.
- **Moves and reset.**
  - MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A on consecutive cycles → both written, with `done` each cycle.
  - `rst_n` low mid-MULT → `hi = lo = 0` and `busy = 0` immediately; no `done`.
